// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    localparam int              XLEN     = 32;
    localparam logic [XLEN-1:0] PC_STEP  = 32'd4;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    // Ceiling log2, used to size pointers and counters at elaboration time.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry (inst, pc) FIFO with synchronous clear; DEPTH must be a power of 2.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  fetch_entry_t     wr_entry,
    output fetch_entry_t     head_entry,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = clog2(DEPTH);

    fetch_entry_t     mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;

    // Entry storage; stale contents are never visible because count gates them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r] <= wr_entry;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else if (clear) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_r + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head_entry = mem_r[rd_ptr_r];
    assign count      = count_r;

endmodule

// File: rtl/inst_fetch_queue_chk.sv
// Occupancy invariants of the fetch queue.
module inst_fetch_queue_chk #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input logic             clk,
    input logic             rst,
    input logic [CNT_W-1:0] count,
    input logic [CNT_W-1:0] inflight,
    input logic [CNT_W-1:0] drop_cnt,
    input logic             push,
    input logic             pop
);

    localparam int SUM_W = CNT_W + 2;

    a_credit_bound: assert property (@(posedge clk) disable iff (rst)
        (SUM_W'(count) + SUM_W'(inflight) + SUM_W'(drop_cnt)) <= SUM_W'(DEPTH));

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (count == CNT_W'(DEPTH))));

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch front end: sequential requests, in-order responses, DEPTH-entry queue, redirect squash.
// Optional 0-cycle response bypass to the output when FETCH_BYPASS_EN is defined.
module inst_fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc
);

    localparam int               CNT_W     = clog2(DEPTH + 1);
    localparam int               SUM_W     = CNT_W + 2;
    localparam logic [SUM_W-1:0] DEPTH_SUM = SUM_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [XLEN-1:0]  fetch_pc_r;
    logic [XLEN-1:0]  resp_pc_r;
    logic [CNT_W-1:0] inflight_r;
    logic [CNT_W-1:0] drop_cnt_r;
    logic             rst_hold_r;
    logic [CNT_W-1:0] count_s;
    logic [SUM_W-1:0] credit_s;
    logic             req_fire_s;
    logic             resp_live_s;
    logic             bypass_s;
    logic             head_valid_s;
    logic             push_s;
    logic             pop_s;
    fetch_entry_t     push_entry_s;
    fetch_entry_t     head_entry_s;

    // inflight counts live requests only; drop_cnt counts squashed ones still owed by memory.
    always_comb begin
        credit_s      = SUM_W'(count_s) + SUM_W'(inflight_r) + SUM_W'(drop_cnt_r);
        mem_req_valid = 1'b0;
        if (!rst && !rst_hold_r && !redirect_valid && (credit_s < DEPTH_SUM)) begin
            mem_req_valid = 1'b1;
        end else begin
            mem_req_valid = 1'b0;
        end
        req_fire_s   = mem_req_valid && mem_req_ready;
        resp_live_s  = !rst && mem_resp_valid && (drop_cnt_r == '0) && !redirect_valid;
`ifdef FETCH_BYPASS_EN
        bypass_s     = resp_live_s && (count_s == '0) && out_ready;
`else
        bypass_s     = 1'b0;
`endif
        head_valid_s = !rst && (count_s != '0) && !redirect_valid;
        push_s       = resp_live_s && !bypass_s;
        pop_s        = head_valid_s && out_ready;
        push_entry_s = '{inst: mem_resp_data, pc: resp_pc_r};
        out_valid    = head_valid_s || bypass_s;
        if (bypass_s) begin
            out_inst = mem_resp_data;
            out_pc   = resp_pc_r;
        end else if (!rst && (count_s != '0)) begin
            out_inst = head_entry_s.inst;
            out_pc   = head_entry_s.pc;
        end else begin
            out_inst = 32'h0000_0000;
            out_pc   = 32'h0000_0000;
        end
    end

    assign mem_req_addr = fetch_pc_r;

    // PC and outstanding-request bookkeeping; redirect overrides everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_r <= RESET_PC;
            resp_pc_r  <= RESET_PC;
            inflight_r <= '0;
            drop_cnt_r <= '0;
            rst_hold_r <= 1'b1;
        end else begin
            rst_hold_r <= 1'b0;
            if (redirect_valid) begin
                fetch_pc_r <= redirect_pc;
                resp_pc_r  <= redirect_pc;
                inflight_r <= '0;
                drop_cnt_r <= drop_cnt_r + inflight_r - CNT_W'(mem_resp_valid);
            end else begin
                if (req_fire_s) begin
                    fetch_pc_r <= fetch_pc_r + PC_STEP;
                end
                if (resp_live_s) begin
                    resp_pc_r <= resp_pc_r + PC_STEP;
                end
                inflight_r <= inflight_r + CNT_W'(req_fire_s) - CNT_W'(resp_live_s);
                if (mem_resp_valid && (drop_cnt_r != '0)) begin
                    drop_cnt_r <= drop_cnt_r - CNT_ONE;
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .clear      (redirect_valid),
        .push       (push_s),
        .pop        (pop_s),
        .wr_entry   (push_entry_s),
        .head_entry (head_entry_s),
        .count      (count_s)
    );

    inst_fetch_queue_chk #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_chk (
        .clk      (clk),
        .rst      (rst),
        .count    (count_s),
        .inflight (inflight_r),
        .drop_cnt (drop_cnt_r),
        .push     (push_s),
        .pop      (pop_s)
    );

endmodule
